// File: rtl/aes_key_sched_ctrl.sv
// AES-128 key schedule controller: emits round keys 0..NR, one word per GEN cycle.
// Optional rk_ready backpressure via AES_KEY_SCHED_BACKPRESSURE_EN.
module aes_key_sched_ctrl #(
   parameter int NK = 4,
   parameter int NR = 10
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         start,
   input  logic [0:127] key,
`ifdef AES_KEY_SCHED_BACKPRESSURE_EN
   input  logic         rk_ready,
`endif
   output logic         busy,
   output logic         rk_valid,
   output logic [3:0]   round_idx,
   output logic [0:127] round_key,
   output logic         done
);

   localparam logic [3:0] NR_L = 4'(NR);

   localparam logic [2047:0] SBOX = {
      128'h637c777bf26b6fc53001672bfed7ab76,
      128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115,
      128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84,
      128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8,
      128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973,
      128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479,
      128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
      128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df,
      128'h8ca1890dbfe6426841992d0fb054bb16
   };

   typedef enum logic [1:0] {IDLE, EMIT, GEN} state_t;

   state_t      state_q, state_d;
   logic [31:0] w_q [NK];
   logic [1:0]  j_q;
   logic [3:0]  rnd_q;
   logic        done_q, done_d;
   logic [0:127] rk_q;
   logic [3:0]  idx_q;
   logic        load, step, ready;
   logic [31:0] rot, sub, t, nw;

   function automatic logic [7:0] sbox(input logic [7:0] x);
      return SBOX[{~x, 3'b000} +: 8];
   endfunction

   function automatic logic [7:0] rcon(input logic [3:0] r);
      case (r)
         4'd1:    return 8'h01;
         4'd2:    return 8'h02;
         4'd3:    return 8'h04;
         4'd4:    return 8'h08;
         4'd5:    return 8'h10;
         4'd6:    return 8'h20;
         4'd7:    return 8'h40;
         4'd8:    return 8'h80;
         4'd9:    return 8'h1b;
         4'd10:   return 8'h36;
         default: return 8'h00;
      endcase
   endfunction

`ifdef AES_KEY_SCHED_BACKPRESSURE_EN
   assign ready = rk_ready;
`else
   assign ready = 1'b1;
`endif

   // j=0 mixes in the transformed last word; later words chain on the fresh one
   assign rot = {w_q[3][23:0], w_q[3][31:24]};
   assign sub = {sbox(rot[31:24]), sbox(rot[23:16]),
                 sbox(rot[15:8]), sbox(rot[7:0])};
   assign t   = (j_q == 2'd0) ? (sub ^ {rcon(rnd_q + 4'd1), 24'h0})
                              : w_q[j_q - 2'd1];
   assign nw  = w_q[j_q] ^ t;

   always_comb begin
      state_d = state_q;
      load    = 1'b0;
      step    = 1'b0;
      done_d  = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) begin
               state_d = EMIT;
               load    = 1'b1;
            end
         end
         EMIT: begin
            if (ready) begin
               if (rnd_q == NR_L) begin
                  state_d = IDLE;
                  done_d  = 1'b1;
               end else begin
                  state_d = GEN;
               end
            end
         end
         GEN: begin
            step = 1'b1;
            if (j_q == 2'd3) state_d = EMIT;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NK; i++) w_q[i] <= '0;
         j_q    <= '0;
         rnd_q  <= '0;
         rk_q   <= '0;
         idx_q  <= '0;
         done_q <= 1'b0;
      end else begin
         done_q <= done_d;
         if (load) begin
            for (int i = 0; i < NK; i++) w_q[i] <= key[32*i +: 32];
            j_q   <= '0;
            rnd_q <= '0;
            rk_q  <= key;
            idx_q <= '0;
         end
         if (step) begin
            w_q[j_q] <= nw;
            j_q      <= j_q + 2'd1;
            if (j_q == 2'd3) begin
               rnd_q <= rnd_q + 4'd1;
               idx_q <= rnd_q + 4'd1;
               rk_q  <= {w_q[0], w_q[1], w_q[2], nw};
            end
         end
      end
   end

   assign busy      = (state_q != IDLE);
   assign rk_valid  = (state_q == EMIT);
   assign round_idx = idx_q;
   assign round_key = rk_q;
   assign done      = done_q;

endmodule

// File: tb/tb_aes_key_sched_ctrl.sv
// Self-checking bench for aes_key_sched_ctrl against an arithmetic AES key-expansion model.
module tb_aes_key_sched_ctrl;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         start;
   logic [0:127] key;
   logic         rk_ready;
   logic         busy, rk_valid, done;
   logic [3:0]   round_idx;
   logic [0:127] round_key;

   int total = 0;
   int bad   = 0;

   logic [127:0] exp_rk [11];
   logic [127:0] cap    [11];

   localparam logic [127:0] FIPS = 128'h2b7e151628aed2a6abf7158809cf4f3c;

   aes_key_sched_ctrl #(.NK(4), .NR(10)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .key       (key),
`ifdef AES_KEY_SCHED_BACKPRESSURE_EN
      .rk_ready  (rk_ready),
`endif
      .busy      (busy),
      .rk_valid  (rk_valid),
      .round_idx (round_idx),
      .round_key (round_key),
      .done      (done)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [127:0] obs,
                      input logic [127:0] expv);
      total++;
      assert (obs === expv) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
      end
   endtask

   function automatic logic [7:0] xt(input logic [7:0] a);
      return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p = 8'h00;
      for (int i = 0; i < 8; i++) begin
         if (b[0]) p = p ^ a;
         a = xt(a);
         b = b >> 1;
      end
      return p;
   endfunction

   // S-box from the GF(2^8) inverse (x^254) followed by the affine map
   function automatic logic [7:0] sb(input logic [7:0] x);
      logic [7:0]  inv = 8'h01;
      logic [7:0]  base = x;
      logic [15:0] d;
      for (int i = 0; i < 8; i++) begin
         if (i != 0) inv = gmul(inv, base);
         base = gmul(base, base);
      end
      if (x == 8'h00) inv = 8'h00;
      d = {inv, inv};
      return inv ^ d[14 -: 8] ^ d[13 -: 8] ^ d[12 -: 8] ^ d[11 -: 8] ^ 8'h63;
   endfunction

   task automatic build(input logic [127:0] k);
      logic [31:0] w [44];
      logic [31:0] t;
      logic [7:0]  rc = 8'h01;
      for (int i = 0; i < 4; i++) w[i] = k[127 - 32*i -: 32];
      for (int i = 4; i < 44; i++) begin
         t = w[i-1];
         if (i % 4 == 0) begin
            t = {t[23:0], t[31:24]};
            t = {sb(t[31:24]), sb(t[23:16]), sb(t[15:8]), sb(t[7:0])};
            t = t ^ {rc, 24'h0};
            rc = xt(rc);
         end
         w[i] = w[i-4] ^ t;
      end
      for (int r = 0; r <= 10; r++)
         exp_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
   endtask

   // Caller raises start with the key at the negedge of cycle 0.
   task automatic run(input int pulse_at, input logic [127:0] k2);
      int r;
      bit em;
      @(posedge clk); @(negedge clk);
      start = 1'b0;
      for (int c = 1; c <= 52; c++) begin
         if (c <= 51) begin
            r  = (c - 1) / 5;
            em = ((c - 1) % 5) == 0;
            chk($sformatf("busy_c%0d", c), busy, 1);
            chk($sformatf("valid_c%0d", c), rk_valid, em);
            chk($sformatf("done_c%0d", c), done, 0);
            chk($sformatf("idx_c%0d", c), round_idx, r);
            chk($sformatf("rk_c%0d", c), round_key, exp_rk[r]);
            if (em) cap[r] = round_key;
         end else begin
            chk("done_c52", done, 1);
            chk("busy_c52", busy, 0);
            chk("valid_c52", rk_valid, 0);
            chk("rk_hold_c52", round_key, exp_rk[10]);
         end
         if (c == pulse_at) begin
            start = 1'b1;
            key   = k2;
         end else if (c < 52) begin
            start = 1'b0;
         end
         if (c < 52) begin
            @(posedge clk); @(negedge clk);
         end
      end
   endtask

   task automatic outs_zero(input string tag);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_valid"}, rk_valid, 0);
      chk({tag, "_done"}, done, 0);
      chk({tag, "_idx"}, round_idx, 0);
      chk({tag, "_rk"}, round_key, 0);
   endtask

   initial begin
      logic [127:0] rkey;
      bit seen;
      rst_n = 1'b0; start = 1'b0; key = '0; rk_ready = 1'b1;
      #2 outs_zero("reset");
      @(negedge clk) rst_n = 1'b1;
      @(negedge clk);

      // reference vector
      build(FIPS);
      start = 1'b1; key = FIPS;
      run(0, '0);
      chk("fips_r0", cap[0], FIPS);
      chk("fips_r1", cap[1], 128'ha0fafe1788542cb123a339392a6c7605);
      chk("fips_r10", cap[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
      @(posedge clk); @(negedge clk);
      chk("done_one_cycle", done, 0);
      chk("idle_busy", busy, 0);

      // all-zero key
      build('0);
      start = 1'b1; key = '0;
      run(0, '0);
      chk("zero_r1", cap[1], 128'h62636363626363636263636362636363);
      chk("zero_r10", cap[10], 128'hb4ef5bcb3e92e21123e951cf6f8f188e);

      // random keys, one starting right in the done cycle of the previous
      for (int n = 0; n < 3; n++) begin
         rkey = {$urandom, $urandom, $urandom, $urandom};
         build(rkey);
         start = 1'b1; key = rkey;
         run(0, '0);
      end
      rkey = {$urandom, $urandom, $urandom, $urandom};
      build(rkey);
      start = 1'b1; key = rkey;
      run(0, '0);

      // start pulsed mid-expansion with a different key is ignored
      build(FIPS);
      start = 1'b1; key = FIPS;
      run(10, {$urandom, $urandom, $urandom, $urandom});
      chk("ignore_r10", cap[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

      // reset during GEN of round 4
      start = 1'b1; key = FIPS;
      @(posedge clk); @(negedge clk);
      start = 1'b0;
      repeat (22) @(negedge clk);
      chk("gen4_idx", round_idx, 4);
      chk("gen4_valid", rk_valid, 0);
      #1 rst_n = 1'b0;
      #1 outs_zero("midreset");
      @(negedge clk) rst_n = 1'b1;
      @(negedge clk);
      outs_zero("postreset");
      start = 1'b1; key = FIPS;
      run(0, '0);

`ifdef AES_KEY_SCHED_BACKPRESSURE_EN
      build(FIPS);
      start = 1'b1; key = FIPS;
      @(posedge clk); @(negedge clk);
      start = 1'b0;
      repeat (10) @(negedge clk);
      rk_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         chk($sformatf("bp_valid_%0d", i), rk_valid, 1);
         chk($sformatf("bp_idx_%0d", i), round_idx, 2);
         chk($sformatf("bp_rk_%0d", i), round_key, exp_rk[2]);
         @(posedge clk); @(negedge clk);
      end
      rk_ready = 1'b1;
      chk("bp_hs_idx", round_idx, 2);
      repeat (5) @(negedge clk);
      chk("bp_r3_valid", rk_valid, 1);
      chk("bp_r3_idx", round_idx, 3);
      chk("bp_r3_rk", round_key, exp_rk[3]);
      seen = 1'b0;
      for (int i = 0; i < 100 && !seen; i++) begin
         @(negedge clk);
         seen = done;
      end
      chk("bp_done_seen", seen, 1);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/aes_key_sched_ctrl.md
AES_KEY_SCHED_CTRL -- requirements
Module: aes_key_sched_ctrl

Interface
REQ-001 The block SHALL have parameter NK, default 4: key length in 32-bit words; only 4 (AES-128) is supported.
REQ-002 The block SHALL have parameter NR, default 10: number of rounds; only 10 is supported.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port start, input, 1 bit: request to expand the key; sampled only in IDLE.
REQ-006 The block SHALL have port key, input, [0:127]: cipher key; byte 0 at bits [0:7].
REQ-007 The block SHALL have port rk_ready, input, 1 bit: consumer accepts round_key (present only with the macro of REQ-026).
REQ-008 The block SHALL have port busy, output, 1 bit: high in every state except IDLE.
REQ-009 The block SHALL have port rk_valid, output, 1 bit: round_key and round_idx are valid.
REQ-010 The block SHALL have port round_idx, output, [3:0]: round number 0..NR of the presented key.
REQ-011 The block SHALL have port round_key, output, [0:127]: words w[4r..4r+3], with w[4r] at bits [0:31].
REQ-012 The block SHALL have port done, output, 1 bit: one-cycle pulse after the round-NR key is accepted.

Function
REQ-013 The FSM SHALL have states IDLE, EMIT and GEN, plus a 4-word register W, a 2-bit word counter j and a 4-bit round counter.
REQ-014 In IDLE, start=1 SHALL load W<=key and round<=0, and move to EMIT; key is not sampled again until the next start.
REQ-015 In EMIT, rk_valid SHALL be 1, round_key SHALL equal W and round_idx SHALL equal round.
REQ-016 In EMIT, a handshake (rk_valid & rk_ready) with round<NR SHALL move to GEN with j=0.
REQ-017 In EMIT, a handshake with round=NR SHALL move to IDLE and assert done for exactly the next cycle.
REQ-018 In GEN, each cycle SHALL compute one word in place: W[j] <= W[j] ^ t.
  - For j=0: t = SubWord(RotWord(W[3])) ^ Rcon(round+1).
  - For j>0: t is the W[j-1] already updated in this round.
  - After j=3: round increments and the FSM returns to EMIT.
REQ-019 RotWord SHALL be the 8-bit left rotation {b1,b2,b3,b0}; SubWord SHALL apply the AES forward S-box to each of the 4 bytes in one cycle.
REQ-020 Rcon(1..10) SHALL be 01,02,04,08,10,20,40,80,1b,36 in the most-significant byte, with the low 24 bits 0; Rcon(other) SHALL be 0.
REQ-021 Latency with rk_ready held at 1 and start sampled at cycle 0:
  - round 0 valid at cycle 1;
  - round r valid at cycle 1+5r;
  - round 10 valid at cycle 51;
  - done at cycle 52;
  - busy falls at cycle 52.
REQ-022 While EMIT waits for rk_ready, round_key and round_idx SHALL hold stable; rk_valid SHALL NOT drop before the handshake.
REQ-023 start while busy=1 SHALL be ignored with no effect on state or outputs; start in the cycle done pulses SHALL be accepted (the FSM is in IDLE).
REQ-024 Outside EMIT, rk_valid SHALL be 0; round_key and round_idx keep their last values.

Reset
REQ-025 Assertion of rst_n=0 at any time, including mid-expansion, SHALL asynchronously force:
  - state IDLE;
  - busy=0, rk_valid=0, done=0;
  - round_idx=0, round_key=0;
  - W=0, j=0, round=0.
  The first start after deassertion SHALL begin a fresh expansion.

Configuration
REQ-026 With AES_KEY_SCHED_BACKPRESSURE_EN defined, rk_ready SHALL exist and gate every EMIT handshake.
REQ-027 Without AES_KEY_SCHED_BACKPRESSURE_EN, rk_ready SHALL be absent and treated internally as 1, so every EMIT lasts exactly one cycle and REQ-021 timing always holds.

Verification
REQ-028 Key 2b7e151628aed2a6abf7158809cf4f3c, rk_ready=1 -> required outputs:
  - round 0 = the key;
  - round 1 = a0fafe1788542cb123a339392a6c7605;
  - round 10 = d014f9a8c9ee2589e13f0cc8b6630ca6 at cycle 51;
  - done at cycle 52.
REQ-029 All-zero key -> round 1 = 62636363626363636263636362636363; round 10 = b4ef5bcb3e92e21123e951cf6f8f188e.
REQ-030 With backpressure, hold rk_ready=0 for 3 cycles at round 2 -> round_idx=2 and round_key stable all 3 cycles; round 3 appears 5 cycles after the handshake.
REQ-031 Pulse start at cycle 10 of an expansion with a different key -> the output sequence is unchanged from REQ-028.
REQ-032 Assert rst_n=0 during GEN of round 4 -> all outputs are 0 immediately; a new start reproduces the REQ-028 sequence from round 0.
REQ-033 Assert start in the done cycle -> a second expansion begins, with round 0 valid in the next cycle.
